bp_nonsynth_commit_checker: RTL and testbench

//  Consumer end of the commit-trace stream: takes golden commit records (pc, instr, rd write)

---
 rtl/bp_nonsynth_pkg.sv | 52 +++++
 rtl/bsg_fifo_1r1w_small.sv | 47 ++++
 rtl/bp_nonsynth_commit_checker.sv | 204 ++++++++++++++++++++
 tb/tb_bp_nonsynth_commit_checker.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_nonsynth_pkg.sv
// Shared types for the nonsynth commit checker: proc config, FSM/fail enums and the
// golden commit record layout.
`ifndef BP_NONSYNTH_PKG_SV
`define BP_NONSYNTH_PKG_SV

`define DECLARE_BP_COMMIT_REC_S(vaddr_width_mp, instr_width_mp, dword_width_mp) \
  typedef struct packed {                                                       \
    logic [vaddr_width_mp-1:0] pc;                                              \
    logic [instr_width_mp-1:0] instr;                                           \
    logic                      rd_w_v;                                          \
    logic [4:0]                rd_addr;                                         \
    logic [dword_width_mp-1:0] rd_data;                                         \
    logic                      last;                                            \
  } bp_commit_rec_s

package bp_nonsynth_pkg;

  typedef enum logic [1:0] {
    e_bp_inv_cfg,
    e_bp_default_cfg,
    e_bp_multicore_4_cfg
  } bp_params_e;

  localparam int unsigned vaddr_width_gp = 39;
  localparam int unsigned instr_width_gp = 32;
  localparam int unsigned dword_width_gp = 64;

  function automatic int unsigned bp_num_core(bp_params_e cfg);
    case (cfg)
      e_bp_multicore_4_cfg: return 4;
      default:              return 1;
    endcase
  endfunction

  typedef enum logic [1:0] {
    e_idle,
    e_run,
    e_done
  } bp_commit_chk_state_e;

  typedef enum logic [2:0] {
    e_fail_none      = 3'd0,
    e_fail_underflow = 3'd1,
    e_fail_pc        = 3'd2,
    e_fail_instr     = 3'd3,
    e_fail_rd        = 3'd4,
    e_fail_timeout   = 3'd5
  } bp_commit_chk_fail_e;

endpackage

`endif

// File: rtl/bsg_fifo_1r1w_small.sv
// Small register-based FIFO with valid/ready enqueue and valid/yumi dequeue.
// Depth must be a power of two; pointers carry one wrap bit to tell full from empty.
module bsg_fifo_1r1w_small #(
  parameter int unsigned els_p   = 8,
  parameter int unsigned width_p = 8,
  localparam int unsigned ptr_w_lp = $clog2(els_p)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic [width_p-1:0]  mem_r [els_p];
  logic [ptr_w_lp:0]   wptr_r, rptr_r;
  logic                empty, full, enq, deq;

  assign empty = (wptr_r == rptr_r);
  assign full  = (wptr_r[ptr_w_lp] != rptr_r[ptr_w_lp])
               & (wptr_r[ptr_w_lp-1:0] == rptr_r[ptr_w_lp-1:0]);

  assign ready_o = ~full;
  assign v_o     = ~empty;
  assign data_o  = mem_r[rptr_r[ptr_w_lp-1:0]];

  assign enq = v_i & ~full;
  assign deq = yumi_i & ~empty;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
    end else begin
      if (enq) wptr_r <= wptr_r + 1'b1;
      if (deq) rptr_r <= rptr_r + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wptr_r[ptr_w_lp-1:0]] <= data_i;
  end

endmodule

// File: rtl/bp_nonsynth_commit_checker.sv
// Compares live core commits, in order, against golden records streamed from a trace reader
// and reports pass or the first failure with its pc.
module bp_nonsynth_commit_checker
  import bp_nonsynth_pkg::*;
#(
  parameter bp_params_e  bp_params_p = e_bp_inv_cfg,
  parameter int unsigned exp_els_p   = 8,
  parameter int unsigned timeout_p   = 4096,
  localparam int unsigned vaddr_width_p = vaddr_width_gp,
  localparam int unsigned instr_width_p = instr_width_gp,
  localparam int unsigned dword_width_p = dword_width_gp,
  localparam int unsigned num_core_p    = bp_num_core(bp_params_p),
  localparam int unsigned hart_w_lp     = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     freeze_i,
  input  logic [hart_w_lp-1:0]     mhartid_i,
  input  logic                     commit_v_i,
  input  logic [vaddr_width_p-1:0] commit_pc_i,
  input  logic [instr_width_p-1:0] commit_instr_i,
  input  logic                     rd_w_v_i,
  input  logic [4:0]               rd_addr_i,
  input  logic [dword_width_p-1:0] rd_data_i,
  input  logic                     exp_v_i,
  output logic                     exp_ready_o,
  input  logic [vaddr_width_p-1:0] exp_pc_i,
  input  logic [instr_width_p-1:0] exp_instr_i,
  input  logic                     exp_rd_w_v_i,
  input  logic [4:0]               exp_rd_addr_i,
  input  logic [dword_width_p-1:0] exp_rd_data_i,
  input  logic                     exp_last_i,
  output logic                     done_o,
  output logic                     pass_o,
  output logic [2:0]               fail_code_o,
  output logic [vaddr_width_p-1:0] fail_pc_o,
  output logic [31:0]              commit_cnt_o
);

  `DECLARE_BP_COMMIT_REC_S(vaddr_width_p, instr_width_p, dword_width_p);

  localparam int unsigned idle_w_lp = (timeout_p == 0) ? 1 : $clog2(timeout_p + 1);
  typedef logic [idle_w_lp-1:0] idle_cnt_t;

  // Hart id is only reported by the surrounding bench, never used here.
  logic unused_hartid;
  assign unused_hartid = ^mhartid_i;

  // Expected-record FIFO
  bp_commit_rec_s                      exp_rec_in, exp_head;
  logic [$bits(bp_commit_rec_s)-1:0]   exp_head_bits;
  logic                                fifo_reset, fifo_ready, fifo_v, fifo_push, fifo_yumi;

  bp_commit_chk_state_e state_r, state_n;

  assign fifo_reset  = ~reset_n_i;
  assign exp_ready_o = fifo_ready & (state_r != e_done);
  assign fifo_push   = exp_v_i & exp_ready_o;
  assign exp_head    = bp_commit_rec_s'(exp_head_bits);

  assign exp_rec_in = '{
    pc:      exp_pc_i,
    instr:   exp_instr_i,
    rd_w_v:  exp_rd_w_v_i,
    rd_addr: exp_rd_addr_i,
    rd_data: exp_rd_data_i,
    last:    exp_last_i
  };

  bsg_fifo_1r1w_small #(
    .els_p   (exp_els_p),
    .width_p ($bits(bp_commit_rec_s))
  ) exp_fifo (
    .clk_i   (clk_i),
    .reset_i (fifo_reset),
    .v_i     (fifo_push),
    .ready_o (fifo_ready),
    .data_i  (exp_rec_in),
    .v_o     (fifo_v),
    .data_o  (exp_head_bits),
    .yumi_i  (fifo_yumi)
  );

  // Check-stage registers
  logic                     freeze_r;
  logic                     commit_v_r;
  logic [vaddr_width_p-1:0] commit_pc_r;
  logic [instr_width_p-1:0] commit_instr_r;
  logic                     rd_w_v_r;
  logic [4:0]               rd_addr_r;
  logic [dword_width_p-1:0] rd_data_r;

  logic                     done_r, done_n;
  logic                     pass_r, pass_n;
  bp_commit_chk_fail_e      fail_code_r, fail_code_n;
  logic [vaddr_width_p-1:0] fail_pc_r, fail_pc_n;
  logic [31:0]              commit_cnt_r, commit_cnt_n;
  idle_cnt_t                idle_cnt_r, idle_cnt_n;

  logic                     check_v;
  bp_commit_chk_fail_e      check_code;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r        <= e_idle;
      freeze_r       <= 1'b1;
      commit_v_r     <= 1'b0;
      commit_pc_r    <= '0;
      commit_instr_r <= '0;
      rd_w_v_r       <= 1'b0;
      rd_addr_r      <= '0;
      rd_data_r      <= '0;
      done_r         <= 1'b0;
      pass_r         <= 1'b0;
      fail_code_r    <= e_fail_none;
      fail_pc_r      <= '0;
      commit_cnt_r   <= '0;
      idle_cnt_r     <= '0;
    end else begin
      state_r        <= state_n;
      freeze_r       <= freeze_i;
      // Commits seen outside RUN are dropped here, before they reach the check stage.
      commit_v_r     <= commit_v_i & (state_r == e_run);
      commit_pc_r    <= commit_pc_i;
      commit_instr_r <= commit_instr_i;
      rd_w_v_r       <= rd_w_v_i;
      rd_addr_r      <= rd_addr_i;
      rd_data_r      <= rd_data_i;
      done_r         <= done_n;
      pass_r         <= pass_n;
      fail_code_r    <= fail_code_n;
      fail_pc_r      <= fail_pc_n;
      commit_cnt_r   <= commit_cnt_n;
      idle_cnt_r     <= idle_cnt_n;
    end
  end

  always_comb begin
    check_v    = (state_r == e_run) & commit_v_r & (commit_pc_r != '0);
    check_code = e_fail_none;
    if (check_v) begin
      if (!fifo_v) begin
        check_code = e_fail_underflow;
      end else if (exp_head.pc != commit_pc_r) begin
        check_code = e_fail_pc;
      end else if (exp_head.instr != commit_instr_r) begin
        check_code = e_fail_instr;
      end else if ((exp_head.rd_w_v != rd_w_v_r)
                   || (exp_head.rd_w_v && rd_w_v_r && (exp_head.rd_addr != '0)
                       && ((exp_head.rd_addr != rd_addr_r)
                           || (exp_head.rd_data != rd_data_r)))) begin
        check_code = e_fail_rd;
      end
    end else if ((state_r == e_run) && (timeout_p != 0)
                 && (32'(idle_cnt_r) + 32'd1 == timeout_p)) begin
      check_code = e_fail_timeout;
    end
  end

  always_comb begin
    state_n      = state_r;
    done_n       = done_r;
    pass_n       = pass_r;
    fail_code_n  = fail_code_r;
    fail_pc_n    = fail_pc_r;
    commit_cnt_n = commit_cnt_r;
    idle_cnt_n   = idle_cnt_r;
    fifo_yumi    = 1'b0;

    unique case (state_r)
      e_idle: begin
        if (freeze_r && !freeze_i) state_n = e_run;
      end
      e_run: begin
        idle_cnt_n = check_v ? '0 : idle_cnt_r + idle_cnt_t'(1);
        fifo_yumi  = check_v & fifo_v;
        if (check_code != e_fail_none) begin
          state_n     = e_done;
          done_n      = 1'b1;
          pass_n      = 1'b0;
          fail_code_n = check_code;
          fail_pc_n   = (check_code == e_fail_timeout) ? '0 : commit_pc_r;
        end else if (check_v) begin
          commit_cnt_n = (commit_cnt_r == '1) ? commit_cnt_r : commit_cnt_r + 32'd1;
          if (exp_head.last) begin
            state_n = e_done;
            done_n  = 1'b1;
            pass_n  = 1'b1;
          end
        end
      end
      e_done: begin
      end
      default: state_n = e_idle;
    endcase
  end

  assign done_o       = done_r;
  assign pass_o       = pass_r;
  assign fail_code_o  = fail_code_r;
  assign fail_pc_o    = fail_pc_r;
  assign commit_cnt_o = commit_cnt_r;

endmodule

// File: tb/tb_bp_nonsynth_commit_checker.sv
// Directed bench: stimulus pushes expected end-of-test results, a monitor pops and compares
// them whenever done_o rises; timeout behaviour is checked on two extra instances.
module tb_bp_nonsynth_commit_checker;
  import bp_nonsynth_pkg::*;

  localparam int unsigned VW = vaddr_width_gp;
  localparam int unsigned IW = instr_width_gp;
  localparam int unsigned DW = dword_width_gp;

  logic          clk = 1'b0;
  logic          reset_n, freeze;
  logic [0:0]    mhartid = '0;
  logic          commit_v, rd_w_v, exp_v, exp_rd_w_v, exp_last;
  logic [VW-1:0] commit_pc, exp_pc;
  logic [IW-1:0] commit_instr, exp_instr;
  logic [4:0]    rd_addr, exp_rd_addr;
  logic [DW-1:0] rd_data, exp_rd_data;
  logic          exp_ready, done, pass;
  logic [2:0]    fail_code;
  logic [VW-1:0] fail_pc;
  logic [31:0]   commit_cnt;

  logic          to_reset_n, to_freeze;
  logic          z1 = 1'b0;
  logic [VW-1:0] zpc = '0;
  logic [IW-1:0] zinstr = '0;
  logic [4:0]    z5 = '0;
  logic [DW-1:0] z64 = '0;
  logic          ready_to, done_to, pass_to, ready_nt, done_nt, pass_nt;
  logic [2:0]    code_to, code_nt;
  logic [VW-1:0] pc_to, pc_nt;
  logic [31:0]   cnt_to, cnt_nt;

  always #5 clk = ~clk;

  bp_nonsynth_commit_checker dut (
    .clk_i(clk), .reset_n_i(reset_n), .freeze_i(freeze), .mhartid_i(mhartid),
    .commit_v_i(commit_v), .commit_pc_i(commit_pc), .commit_instr_i(commit_instr),
    .rd_w_v_i(rd_w_v), .rd_addr_i(rd_addr), .rd_data_i(rd_data),
    .exp_v_i(exp_v), .exp_ready_o(exp_ready), .exp_pc_i(exp_pc), .exp_instr_i(exp_instr),
    .exp_rd_w_v_i(exp_rd_w_v), .exp_rd_addr_i(exp_rd_addr), .exp_rd_data_i(exp_rd_data),
    .exp_last_i(exp_last), .done_o(done), .pass_o(pass), .fail_code_o(fail_code),
    .fail_pc_o(fail_pc), .commit_cnt_o(commit_cnt)
  );

  bp_nonsynth_commit_checker #(.timeout_p(16)) dut_to (
    .clk_i(clk), .reset_n_i(to_reset_n), .freeze_i(to_freeze), .mhartid_i(mhartid),
    .commit_v_i(z1), .commit_pc_i(zpc), .commit_instr_i(zinstr),
    .rd_w_v_i(z1), .rd_addr_i(z5), .rd_data_i(z64),
    .exp_v_i(z1), .exp_ready_o(ready_to), .exp_pc_i(zpc), .exp_instr_i(zinstr),
    .exp_rd_w_v_i(z1), .exp_rd_addr_i(z5), .exp_rd_data_i(z64),
    .exp_last_i(z1), .done_o(done_to), .pass_o(pass_to), .fail_code_o(code_to),
    .fail_pc_o(pc_to), .commit_cnt_o(cnt_to)
  );

  bp_nonsynth_commit_checker #(.timeout_p(0)) dut_nt (
    .clk_i(clk), .reset_n_i(to_reset_n), .freeze_i(to_freeze), .mhartid_i(mhartid),
    .commit_v_i(z1), .commit_pc_i(zpc), .commit_instr_i(zinstr),
    .rd_w_v_i(z1), .rd_addr_i(z5), .rd_data_i(z64),
    .exp_v_i(z1), .exp_ready_o(ready_nt), .exp_pc_i(zpc), .exp_instr_i(zinstr),
    .exp_rd_w_v_i(z1), .exp_rd_addr_i(z5), .exp_rd_data_i(z64),
    .exp_last_i(z1), .done_o(done_nt), .pass_o(pass_nt), .fail_code_o(code_nt),
    .fail_pc_o(pc_nt), .commit_cnt_o(cnt_nt)
  );

  typedef struct {
    int            tag;
    logic          pass;
    logic [2:0]    code;
    logic [VW-1:0] pc;
    logic [31:0]   cnt;
  } result_t;

  result_t sb[$];
  int      total = 0;
  int      bad = 0;
  logic    done_seen = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_result(input int tag, input logic p, input logic [2:0] code,
                               input logic [VW-1:0] pc, input logic [31:0] cnt);
    result_t r;
    r.tag = tag; r.pass = p; r.code = code; r.pc = pc; r.cnt = cnt;
    sb.push_back(r);
  endtask

  // Monitor: one scoreboard entry per rising done_o.
  always @(negedge clk) begin
    result_t r;
    if (reset_n && done && !done_seen) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'd0);
      end else begin
        r = sb.pop_front();
        chk($sformatf("t%0d.pass", r.tag), 64'(pass), 64'(r.pass));
        chk($sformatf("t%0d.fail_code", r.tag), 64'(fail_code), 64'(r.code));
        chk($sformatf("t%0d.fail_pc", r.tag), 64'(fail_pc), 64'(r.pc));
        chk($sformatf("t%0d.commit_cnt", r.tag), 64'(commit_cnt), 64'(r.cnt));
      end
    end
    done_seen = reset_n & done;
  end

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_wait_expired", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; freeze = 1'b1;
    commit_v = 0; commit_pc = '0; commit_instr = '0; rd_w_v = 0; rd_addr = '0; rd_data = '0;
    exp_v = 0; exp_pc = '0; exp_instr = '0; exp_rd_w_v = 0; exp_rd_addr = '0; exp_rd_data = '0;
    exp_last = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [VW-1:0] pc, input logic [IW-1:0] instr, input logic w,
                      input logic [4:0] a, input logic [DW-1:0] d, input logic last);
    exp_v = 1; exp_pc = pc; exp_instr = instr; exp_rd_w_v = w; exp_rd_addr = a;
    exp_rd_data = d; exp_last = last;
    @(posedge clk); #1;
    exp_v = 0;
  endtask

  task automatic commit(input logic [VW-1:0] pc, input logic [IW-1:0] instr, input logic w,
                        input logic [4:0] a, input logic [DW-1:0] d);
    commit_v = 1; commit_pc = pc; commit_instr = instr; rd_w_v = w; rd_addr = a; rd_data = d;
    @(posedge clk); #1;
    commit_v = 0;
  endtask

  task automatic drop_freeze();
    freeze = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit actual=expired required=finished");
    $fatal(1, "time limit");
  end

  initial begin
    to_reset_n = 1'b0; to_freeze = 1'b1;
    do_reset();

    // Reset values
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.pass", 64'(pass), 64'd0);
    chk("rst.fail_code", 64'(fail_code), 64'd0);
    chk("rst.fail_pc", 64'(fail_pc), 64'd0);
    chk("rst.commit_cnt", 64'(commit_cnt), 64'd0);
    chk("rst.exp_ready", 64'(exp_ready), 64'd1);

    // 1: three matching commits, last on #3
    push(39'h80000000, 32'h00100093, 1, 5'd1, 64'd1, 0);
    push(39'h80000004, 32'h00200113, 1, 5'd2, 64'd2, 0);
    push(39'h80000008, 32'h00300193, 1, 5'd3, 64'd3, 1);
    expect_result(1, 1'b1, 3'd0, '0, 32'd3);
    drop_freeze();
    commit(39'h80000000, 32'h00100093, 1, 5'd1, 64'd1);
    commit(39'h80000004, 32'h00200113, 1, 5'd2, 64'd2);
    commit(39'h80000008, 32'h00300193, 1, 5'd3, 64'd3);
    wait_drain(20);
    chk("t1.exp_ready_in_done", 64'(exp_ready), 64'd0);

    // 2: instr mismatch on record #2
    do_reset();
    push(39'h80000000, 32'h00000013, 0, 5'd0, 64'd0, 0);
    push(39'h80000004, 32'h00000013, 0, 5'd0, 64'd0, 0);
    push(39'h80000008, 32'h00000013, 0, 5'd0, 64'd0, 1);
    expect_result(2, 1'b0, 3'd3, 39'h80000004, 32'd1);
    drop_freeze();
    commit(39'h80000000, 32'h00000013, 0, 5'd0, 64'd0);
    commit(39'h80000004, 32'h00100093, 0, 5'd0, 64'd0);
    wait_drain(20);
    commit(39'h80000008, 32'h00000013, 0, 5'd0, 64'd0);
    @(posedge clk); #1;
    chk("t2.cnt_frozen_after_done", 64'(commit_cnt), 64'd1);

    // 3: underflow even though a push lands in the check cycle
    do_reset();
    expect_result(3, 1'b0, 3'd1, 39'h80000000, 32'd0);
    drop_freeze();
    commit(39'h80000000, 32'h00000013, 0, 5'd0, 64'd0);
    push(39'h80000000, 32'h00000013, 0, 5'd0, 64'd0, 1);
    wait_drain(20);

    // 4: x0 write data ignored, x5 data mismatch flagged
    do_reset();
    push(39'h80000000, 32'h00000013, 1, 5'd0, 64'd0, 0);
    push(39'h80000004, 32'h000002b7, 1, 5'd5, 64'hdead, 0);
    push(39'h80000008, 32'h00000013, 0, 5'd0, 64'd0, 1);
    expect_result(4, 1'b0, 3'd4, 39'h80000004, 32'd1);
    drop_freeze();
    commit(39'h80000000, 32'h00000013, 1, 5'd0, 64'h1234);
    commit(39'h80000004, 32'h000002b7, 1, 5'd5, 64'hbeef);
    wait_drain(20);

    // 7: pc mismatch on the first record
    do_reset();
    push(39'h80000000, 32'h00000013, 0, 5'd0, 64'd0, 1);
    expect_result(7, 1'b0, 3'd2, 39'h80000010, 32'd0);
    drop_freeze();
    commit(39'h80000010, 32'h00000013, 0, 5'd0, 64'd0);
    wait_drain(20);

    // 5: watchdog at 16 idle RUN cycles; disabled watchdog never finishes
    #1 to_reset_n = 1'b1;
    @(posedge clk); #1;
    to_freeze = 1'b0;
    @(posedge clk); #1;
    repeat (15) @(posedge clk);
    #1;
    chk("t5.done_before_16", 64'(done_to), 64'd0);
    @(posedge clk); #1;
    chk("t5.done_at_16", 64'(done_to), 64'd1);
    chk("t5.fail_code", 64'(code_to), 64'd5);
    chk("t5.fail_pc", 64'(pc_to), 64'd0);
    chk("t5.pass", 64'(pass_to), 64'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("t5.no_timeout_done", 64'(done_nt), 64'd0);

    // 6: full FIFO, pc=0 skip, reset mid-RUN
    do_reset();
    for (int i = 0; i < 8; i++)
      push(39'h80000000 + 39'(4 * i), 32'h00000013, 0, 5'd0, 64'd0, 0);
    chk("t6.exp_ready_full", 64'(exp_ready), 64'd0);
    drop_freeze();
    commit('0, 32'h00000013, 0, 5'd0, 64'd0);
    commit('0, 32'hdeadbeef, 1, 5'd7, 64'd9);
    commit(39'h80000000, 32'h00000013, 0, 5'd0, 64'd0);
    @(posedge clk); #1;
    chk("t6.cnt_after_skips", 64'(commit_cnt), 64'd1);
    chk("t6.exp_ready_after_pop", 64'(exp_ready), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("t6.rst_cnt", 64'(commit_cnt), 64'd0);
    chk("t6.rst_done", 64'(done), 64'd0);
    chk("t6.rst_exp_ready", 64'(exp_ready), 64'd1);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    expect_result(6, 1'b0, 3'd1, 39'h80000004, 32'd0);
    commit(39'h80000004, 32'h00000013, 0, 5'd0, 64'd0);
    wait_drain(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
